// File: rtl/light_pkg.sv
// Shared types and constants for the light step command generator and its level counter.
// Build option LIGHT_AUTO_REPEAT_EN (see light_step_cmd_gen.sv) does not affect this package.
package light_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DELAY    = 2'd1,
    ST_REPEAT   = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

  localparam int unsigned LEVEL_MIN = 0;
  localparam int unsigned LEVEL_MAX = 4;
  localparam int unsigned LEVEL_RST = 2;

endpackage

// File: rtl/light_step_cmd_gen_if.sv
// Button-side and counter-side signals of light_step_cmd_gen, plus FSM debug state.
// Build option LIGHT_AUTO_REPEAT_EN changes only the meaning of held (tied 0 when undefined).
interface light_step_cmd_gen_if;
  import light_pkg::*;

  // Pulse contract: up_count/down_count are registered, one cycle wide, never both high,
  // and never asserted while on=0; the receiver must act on every cycle a pulse is high.
  logic   on;
  logic   btn_up_raw;
  logic   btn_down_raw;
  logic   up_count;
  logic   down_count;
  logic   held;
  state_t state_dbg;

  modport master (
    output on, btn_up_raw, btn_down_raw,
    input  up_count, down_count, held, state_dbg
  );

  modport slave (
    input  on, btn_up_raw, btn_down_raw,
    output up_count, down_count, held, state_dbg
  );

endinterface

// File: rtl/light_btn_debounce.sv
// Two-flop synchroniser plus debounce for one raw pushbutton; emits the debounced
// level and a one-cycle rise flag when that level goes high.
module light_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter tracks consecutive cycles the synced input disagrees with the level;
  // any agreement clears it, and it cannot exceed CNT_LAST because reaching it flips.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q >= CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/light_step_cmd_gen.sv
// Turns raw up/down buttons into single-cycle up_count/down_count step pulses.
// Define LIGHT_AUTO_REPEAT_EN to get auto-repeat while a button is held.
module light_step_cmd_gen
  import light_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  light_step_cmd_gen_if.slave  bus
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
    $error("light_step_cmd_gen: timing parameters must be at least 2");
  end

  logic lvl_up, rise_up, lvl_dn, rise_dn;

  light_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.btn_up_raw),
    .level (lvl_up),
    .rise  (rise_up)
  );

  light_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.btn_down_raw),
    .level (lvl_dn),
    .rise  (rise_dn)
  );

  state_t state_q, state_d;
  dir_t   dir_q, dir_d;
  logic   up_q, up_d;
  logic   dn_q, dn_d;

`ifdef LIGHT_AUTO_REPEAT_EN
  localparam int unsigned   TMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned   TW          = $clog2(TMAX + 1);
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          dir_lvl, other_lvl;
  logic [TW-1:0] timer_last;

  assign dir_lvl    = (dir_q == DIR_UP) ? lvl_up : lvl_dn;
  assign other_lvl  = (dir_q == DIR_UP) ? lvl_dn : lvl_up;
  assign timer_last = (state_q == ST_DELAY) ? DELAY_LAST : PERIOD_LAST;
`endif

  // A press is only accepted on the debounced rising edge, so a button already
  // held when on rises, or when the FSM returns to IDLE, does not step.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
`ifdef LIGHT_AUTO_REPEAT_EN
    timer_d = timer_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.on && (rise_up || rise_dn)) begin
          if (lvl_up && lvl_dn) begin
            state_d = ST_WAIT_REL;
          end else begin
            dir_d = rise_up ? DIR_UP : DIR_DN;
            up_d  = rise_up;
            dn_d  = ~rise_up;
`ifdef LIGHT_AUTO_REPEAT_EN
            state_d = ST_DELAY;
            timer_d = '0;
`else
            state_d = ST_WAIT_REL;
`endif
          end
        end
      end
`ifdef LIGHT_AUTO_REPEAT_EN
      ST_DELAY, ST_REPEAT: begin
        if (!dir_lvl) begin
          state_d = ST_IDLE;
        end else if (other_lvl || !bus.on) begin
          state_d = ST_WAIT_REL;
        end else if (timer_q >= timer_last) begin
          up_d    = (dir_q == DIR_UP);
          dn_d    = (dir_q == DIR_DN);
          state_d = ST_REPEAT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      ST_WAIT_REL: begin
        if (!lvl_up && !lvl_dn) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
`ifdef LIGHT_AUTO_REPEAT_EN
      timer_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
`ifdef LIGHT_AUTO_REPEAT_EN
      timer_q <= timer_d;
`endif
    end
  end

  assign bus.up_count   = up_q;
  assign bus.down_count = dn_q;
  assign bus.state_dbg  = state_q;
`ifdef LIGHT_AUTO_REPEAT_EN
  assign bus.held = (state_q == ST_DELAY) || (state_q == ST_REPEAT);
`else
  assign bus.held = 1'b0;
`endif

endmodule
